pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter NUM_REGS, 32, architectural register count; register 0 is hardwired zero.
REQ-002 Parameter CNT_W, 2, width of each per-register in-flight write counter (max 3 pending writes).
REQ-003 Parameter STALL_CNT_W, 16, width of the stall-cycle performance counter.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 id_valid  in  1  decode slot holds a real (non-bubble) instruction.
REQ-007 id_rs0 / id_rs1  in  5 each  source register indices; id_rs0_en / id_rs1_en  in  1 each  source actually read.
REQ-008 id_rd  in  5  destination index; id_rd_en  in  1  instruction writes id_rd.
REQ-009 wb_valid  in  1  a register write retires this cycle; wb_rd  in  5  its index.
REQ-010 drain_req  in  1  level request to empty the pipeline of pending writes.
REQ-011 stall  out  1  drives decode-stage stall; decode inserts a no-op when high.
REQ-012 drain_done  out  1  one-cycle pulse: pipeline drained.
REQ-013 pending  out  NUM_REGS  bitmap, bit i = counter i nonzero.
REQ-014 stall_cycles  out  STALL_CNT_W  saturating count of cycles with stall high.
REQ-015 sb_err  out  1  sticky scoreboard error flag.

Function
REQ-016 issue = id_valid & ~stall; only issued instructions update the scoreboard.
REQ-017 On issue with id_rd_en and id_rd != 0, count[id_rd] increments at the next edge.
REQ-018 On wb_valid and wb_rd != 0 with count[wb_rd] > 0, count[wb_rd] decrements at the next edge.
REQ-019 Issue and writeback to the same register in one cycle leave that count unchanged.
REQ-020 Writeback to a register with count 0 leaves count at 0 and sets sb_err.
REQ-021 Index 0 is never counted, never pending, never causes a hazard.
REQ-022 hazard = (id_rs0_en & rs0!=0 & pending[rs0]) | (id_rs1_en & rs1!=0 & pending[rs1]) | (id_rd_en & rd!=0 & count[rd]==max), qualified by id_valid.
REQ-023 Hazard uses registered counts only; a same-cycle writeback does not release a stall until the next cycle (no bypass).
REQ-024 stall is combinational, same cycle: stall = hazard | (state != RUN).
REQ-025 FSM states RUN, DRAIN, DONE; reset state RUN.
REQ-026 RUN -> DRAIN when drain_req=1 at an edge; drain_req ignored outside RUN.
REQ-027 DRAIN -> DONE when all counts are zero; DRAIN holds otherwise, stall=1 throughout.
REQ-028 DONE: drain_done=1, stall=1, unconditionally -> RUN next cycle.
REQ-029 drain_req asserted with scoreboard already empty still takes RUN -> DRAIN -> DONE (two stall cycles).
REQ-030 stall_cycles increments each cycle stall=1, holds at all-ones.

Reset
REQ-031 rst asserted clears all counts, pending=0, state=RUN, drain_done=0, stall_cycles=0, sb_err=0, immediately and independent of clk.
REQ-032 Reset mid-DRAIN abandons the drain; no drain_done pulse is produced.
REQ-033 After deassertion, stall reflects only hazard logic on empty scoreboard (i.e., 0 until first issue).

Structure
REQ-034 Shared package holds FSM state encoding (RUN=0, DRAIN=1, DONE=2) and the register-index width constant (5).
REQ-035 One sub-module, sb_counter: a CNT_W saturating up/down counter with inc, dec, zero and full outputs and the error strobe, instantiated NUM_REGS-1 times.

Verification
REQ-036 Issue rd=5; next cycle rs0=5 -> stall=1 until wb_rd=5 retires, stall=0 the cycle after.
REQ-037 Issue rd=0 then read rs1=0 -> stall never asserts, pending=0.
REQ-038 Issue rd=7 three times, fourth write to 7 -> stall=1 (full); one wb_rd=7 -> fourth issues next cycle.
REQ-039 Same-cycle issue rd=3 and wb_rd=3 with count[3]=1 -> count[3] stays 1, pending[3]=1.
REQ-040 Two pending, drain_req pulse -> stall=1, drain_done pulses exactly once one cycle after last wb; stall_cycles increases by matching amount.
REQ-041 wb_rd=9 with count 0 -> sb_err=1 and stays 1 until rst; rst mid-DRAIN -> state RUN, no drain_done.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the decode-stage hazard controller.
// Holds the drain FSM encoding and the register index width.
// No logic: no latency, no backpressure.
package pipeline_hazard_ctrl_pkg;

    localparam int REG_IDX_W = 5;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } hz_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode/writeback/drain bundle between pipeline control and the hazard block.
// Pure wiring: zero latency.
// stall is the only backpressure, returned to the decode side on the same cycle.
interface pipeline_hazard_ctrl_if #(
    parameter int NUM_REGS    = 32,
    parameter int STALL_CNT_W = 16
);
    import pipeline_hazard_ctrl_pkg::*;

    logic                   id_valid;
    logic [REG_IDX_W-1:0]   id_rs0;
    logic                   id_rs0_en;
    logic [REG_IDX_W-1:0]   id_rs1;
    logic                   id_rs1_en;
    logic [REG_IDX_W-1:0]   id_rd;
    logic                   id_rd_en;
    logic                   wb_valid;
    logic [REG_IDX_W-1:0]   wb_rd;
    logic                   drain_req;

    logic                   stall;
    logic                   drain_done;
    logic [NUM_REGS-1:0]    pending;
    logic [STALL_CNT_W-1:0] stall_cycles;
    logic                   sb_err;

    modport master (
        output id_valid, id_rs0, id_rs0_en, id_rs1, id_rs1_en, id_rd, id_rd_en,
        output wb_valid, wb_rd, drain_req,
        input  stall, drain_done, pending, stall_cycles, sb_err
    );

    modport slave (
        input  id_valid, id_rs0, id_rs0_en, id_rs1, id_rs1_en, id_rd, id_rd_en,
        input  wb_valid, wb_rd, drain_req,
        output stall, drain_done, pending, stall_cycles, sb_err
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_sb_counter.sv
// Per-register in-flight write counter, saturating at both ends.
// Count updates one edge after inc/dec; zero/full/err are combinational.
// No backpressure: callers must not inc when full (held, not wrapped).
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic zero,
    output logic full,
    output logic err
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             do_dec;

    assign zero   = (cnt_q == '0);
    assign full   = &cnt_q;
    assign err    = dec & zero;
    // A writeback against an empty count is dropped, so a same-cycle issue still lands.
    assign do_dec = dec & ~zero;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({inc, do_dec})
            2'b10:   if (!full) cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Decode-stage RAW/WAW-depth hazard scoreboard with a drain-the-pipeline FSM.
// stall is combinational from registered counts; counts/FSM update on the next edge.
// Backpressure: stall holds decode while a source is pending, rd is full, or not in RUN.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int NUM_REGS    = 32,
    parameter int CNT_W       = 2,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_hazard_ctrl_if.slave  bus
);

    logic [NUM_REGS-1:1]    inc_vec;
    logic [NUM_REGS-1:1]    dec_vec;
    logic [NUM_REGS-1:1]    zero_vec;
    logic [NUM_REGS-1:1]    full_vec;
    logic [NUM_REGS-1:1]    err_vec;

    logic [NUM_REGS-1:0]    pending_all;
    logic [NUM_REGS-1:0]    full_all;

    logic                   rs0_hit;
    logic                   rs1_hit;
    logic                   rd_hit;
    logic                   hazard;
    logic                   stall;
    logic                   issue;
    logic                   all_zero;

    hz_state_e              state_q;
    hz_state_e              state_d;
    logic                   sb_err_q;
    logic                   sb_err_d;
    logic [STALL_CNT_W-1:0] stall_cycles_q;
    logic [STALL_CNT_W-1:0] stall_cycles_d;

    // Register 0 has no counter: it reads as never pending and never full.
    for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
        assign inc_vec[g] = issue & bus.id_rd_en & (bus.id_rd == REG_IDX_W'(g));
        assign dec_vec[g] = bus.wb_valid & (bus.wb_rd == REG_IDX_W'(g));

        sb_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk  (clk),
            .rst  (rst),
            .inc  (inc_vec[g]),
            .dec  (dec_vec[g]),
            .zero (zero_vec[g]),
            .full (full_vec[g]),
            .err  (err_vec[g])
        );
    end

    assign pending_all = {~zero_vec, 1'b0};
    assign full_all    = {full_vec, 1'b0};
    assign all_zero    = ~|pending_all;

    always_comb begin
        rs0_hit = bus.id_rs0_en & (bus.id_rs0 != '0) & pending_all[bus.id_rs0];
        rs1_hit = bus.id_rs1_en & (bus.id_rs1 != '0) & pending_all[bus.id_rs1];
        rd_hit  = bus.id_rd_en  & (bus.id_rd  != '0) & full_all[bus.id_rd];
        hazard  = bus.id_valid & (rs0_hit | rs1_hit | rd_hit);
        stall   = hazard | (state_q != ST_RUN);
        issue   = bus.id_valid & ~stall;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:   if (bus.drain_req) state_d = ST_DRAIN;
            ST_DRAIN: if (all_zero)      state_d = ST_DONE;
            ST_DONE:  state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_comb begin
        sb_err_d       = sb_err_q | (|err_vec);
        stall_cycles_d = stall_cycles_q;
        if (stall && !(&stall_cycles_q)) begin
            stall_cycles_d = stall_cycles_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_RUN;
            sb_err_q       <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            sb_err_q       <= sb_err_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign bus.stall        = stall;
    assign bus.drain_done   = (state_q == ST_DONE);
    assign bus.pending      = pending_all;
    assign bus.stall_cycles = stall_cycles_q;
    assign bus.sb_err       = sb_err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: a per-cycle reference model pushes expected outputs, a monitor compares them.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_MAX = 3;
    localparam int SC_MAX  = 65535;
    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_DONE  = 2;

    typedef struct {
        logic        stall;
        logic        dd;
        logic        err;
        logic [31:0] pend;
        logic [15:0] sc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pipeline_hazard_ctrl_if #(.NUM_REGS(32), .STALL_CNT_W(16)) bus ();

    pipeline_hazard_ctrl #(
        .NUM_REGS    (32),
        .CNT_W       (2),
        .STALL_CNT_W (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t expq[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: pending writes per register, drain mode, sticky error, stall count.
    int   cnt[32];
    int   mode;
    bit   m_err;
    int   m_sc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pend_of();
        logic [31:0] p = '0;
        for (int i = 1; i < 32; i++) p[i] = (cnt[i] > 0);
        return p;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) cnt[i] = 0;
        mode  = M_RUN;
        m_err = 1'b0;
        m_sc  = 0;
    endtask

    task automatic zero_inputs();
        bus.id_valid  = 1'b0;
        bus.id_rs0    = '0;
        bus.id_rs0_en = 1'b0;
        bus.id_rs1    = '0;
        bus.id_rs1_en = 1'b0;
        bus.id_rd     = '0;
        bus.id_rd_en  = 1'b0;
        bus.wb_valid  = 1'b0;
        bus.wb_rd     = '0;
        bus.drain_req = 1'b0;
    endtask

    // One clock cycle: drive inputs, push what the outputs must be, advance the model.
    task automatic cyc(input bit v, input int rs0, input bit rs0e, input int rs1, input bit rs1e,
                       input int rd, input bit rde, input bit wbv, input int wbr, input bit dr);
        exp_t e;
        bit   haz, stl, iss, empty;
        int   nc[32];
        @(posedge clk);
        #1;
        bus.id_valid  = v;
        bus.id_rs0    = 5'(rs0);
        bus.id_rs0_en = rs0e;
        bus.id_rs1    = 5'(rs1);
        bus.id_rs1_en = rs1e;
        bus.id_rd     = 5'(rd);
        bus.id_rd_en  = rde;
        bus.wb_valid  = wbv;
        bus.wb_rd     = 5'(wbr);
        bus.drain_req = dr;

        haz = v && ((rs0e && rs0 != 0 && cnt[rs0] > 0) ||
                    (rs1e && rs1 != 0 && cnt[rs1] > 0) ||
                    (rde  && rd  != 0 && cnt[rd] == CNT_MAX));
        stl = haz || (mode != M_RUN);
        e.stall = stl;
        e.dd    = (mode == M_DONE);
        e.err   = m_err;
        e.pend  = pend_of();
        e.sc    = 16'(m_sc);
        expq.push_back(e);

        empty = (pend_of() == 32'd0);
        iss   = v && !stl;
        nc    = cnt;
        if (iss && rde && rd != 0) nc[rd] = nc[rd] + 1;
        if (wbv && wbr != 0) begin
            if (cnt[wbr] > 0) nc[wbr] = nc[wbr] - 1;
            else              m_err = 1'b1;
        end
        cnt = nc;
        case (mode)
            M_RUN:   if (dr) mode = M_DRAIN;
            M_DRAIN: if (empty) mode = M_DONE;
            default: mode = M_RUN;
        endcase
        if (stl && m_sc < SC_MAX) m_sc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic issue_rd(input int rd);
        cyc(1, 0, 0, 0, 0, rd, 1, 0, 0, 0);
    endtask

    task automatic wb(input int r);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, r, 0);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before any further clock edge.
    task automatic mid_reset();
        @(posedge clk);
        #7;
        zero_inputs();
        rst = 1'b1;
        #1;
        chk("rst_stall",   64'(bus.stall),        64'd0);
        chk("rst_dd",      64'(bus.drain_done),   64'd0);
        chk("rst_pending", 64'(bus.pending),      64'd0);
        chk("rst_sc",      64'(bus.stall_cycles), 64'd0);
        chk("rst_err",     64'(bus.sb_err),       64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("stall",        64'(bus.stall),        64'(e.stall));
                chk("drain_done",   64'(bus.drain_done),   64'(e.dd));
                chk("sb_err",       64'(bus.sb_err),       64'(e.err));
                chk("pending",      64'(bus.pending),      64'(e.pend));
                chk("stall_cycles", 64'(bus.stall_cycles), 64'(e.sc));
            end
        end
    end

    initial begin : stim
        int cand[$];
        int wr;
        zero_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        chk("init_stall",   64'(bus.stall),        64'd0);
        chk("init_pending", 64'(bus.pending),      64'd0);
        chk("init_sc",      64'(bus.stall_cycles), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // RAW on r5 held until its writeback has retired
        issue_rd(5);
        repeat (2) cyc(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 5, 1, 0, 0, 0, 0, 1, 5, 0);
        cyc(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);

        // r0 is never tracked
        issue_rd(0);
        cyc(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 1, 0, 1, 1, 0, 0);

        // r7 depth limit of three pending writes
        repeat (3) issue_rd(7);
        repeat (2) issue_rd(7);
        cyc(1, 0, 0, 0, 0, 7, 1, 1, 7, 0);
        issue_rd(7);
        repeat (3) wb(7);

        // simultaneous issue and writeback on r3
        issue_rd(3);
        cyc(1, 0, 0, 0, 0, 3, 1, 1, 3, 0);
        idle(1);
        wb(3);

        // drain with two writes outstanding
        issue_rd(10);
        issue_rd(11);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 1, 1, 0, 0, 2, 1, 0, 0, 0);
        idle(1);
        wb(10);
        idle(1);
        wb(11);
        idle(4);

        // drain on an already empty scoreboard
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(3);

        // orphan writeback, then reset during a drain
        wb(9);
        idle(1);
        issue_rd(12);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);
        mid_reset();
        idle(3);
        issue_rd(12);
        cyc(1, 12, 1, 0, 0, 0, 0, 1, 12, 0);
        idle(2);

        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) mid_reset();
            cand.delete();
            for (int i = 1; i < 8; i++) if (cnt[i] > 0) cand.push_back(i);
            wr = 0;
            if (cand.size() > 0 && $urandom_range(0, 1) == 1)
                wr = cand[$urandom_range(0, cand.size() - 1)];
            else if ($urandom_range(0, 59) == 0)
                wr = $urandom_range(0, 7);
            cyc($urandom_range(0, 3) != 0,
                $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                $urandom_range(0, 7), $urandom_range(0, 2) != 0,
                wr != 0 || $urandom_range(0, 9) == 0, wr,
                $urandom_range(0, 39) == 0);
        end

        idle(2);
        repeat (3) @(negedge clk);
        #1;
        chk("queue_empty", 64'(expq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
